// File: rtl/inner_product_firing_fsm_n.sv
`default_nettype none
// ============================================================================
// Module   : inner_product_firing_fsm_n
// Purpose  : Firing-state controller for the inner-product CFDF actor.
//            Modes: LOAD, COMPUTE, WRITE, CLEAR. Runtime length, FIFO
//            back-pressure, saturated result.
// Revision : 1.0 - initial release
// ============================================================================
module inner_product_firing_fsm_n #(
   parameter int SIZE      = 8,
   parameter int WIDTH     = 16,
   parameter int ACC_WIDTH = 2*WIDTH + $clog2(SIZE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_in,
   input  logic [1:0]       next_mode_in,
   input  logic [WIDTH-1:0] len_in,
   input  logic             len_empty,
   input  logic [WIDTH-1:0] data_a_in,
   input  logic             empty_a,
   input  logic [WIDTH-1:0] data_b_in,
   input  logic             empty_b,
   input  logic             out_full,
   output logic             rd_len,
   output logic             rd_a,
   output logic             rd_b,
   output logic             wr_out,
   output logic [WIDTH-1:0] result_out,
   output logic             sat_out,
   output logic             len_err,
   output logic [1:0]       next_mode_out,
   output logic             done_out
);

   localparam int CW    = $clog2(SIZE + 1);
   localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int DEPTH = 1 << AW;
   localparam int LW    = (WIDTH > 32) ? WIDTH : 32;

   localparam logic [1:0] M_LOAD  = 2'b00;
   localparam logic [1:0] M_COMP  = 2'b01;
   localparam logic [1:0] M_WRITE = 2'b10;

   localparam logic [CW-1:0] SIZE_C = CW'(SIZE);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   localparam logic signed [ACC_WIDTH-1:0] MAX_V =
      {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] MIN_V =
      {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_LOAD  = 3'd2,
      S_COMP  = 3'd3,
      S_DRAIN = 3'd4,
      S_WRITE = 3'd5,
      S_END   = 3'd6
   } state_t;

   state_t                      state;
   logic [CW-1:0]               len_q;
   logic [CW-1:0]               idx;
   logic                        mac_valid;
   logic signed [ACC_WIDTH-1:0] acc;

   logic [WIDTH-1:0] ram_a [DEPTH];
   logic [WIDTH-1:0] ram_b [DEPTH];
   logic [WIDTH-1:0] rdata_a;
   logic [WIDTH-1:0] rdata_b;

   logic                        w_pop;
   logic [AW-1:0]               w_addr;
   logic                        w_len_over;
   logic [CW-1:0]               w_len;
   logic signed [2*WIDTH-1:0]   w_prod;
   logic signed [ACC_WIDTH-1:0] w_prod_ext;

   assign w_pop      = (state == S_LOAD) && !empty_a && !empty_b;
   assign w_addr     = idx[AW-1:0];
   assign w_len_over = LW'(len_in) > LW'(SIZE);
   assign w_len      = w_len_over ? SIZE_C : CW'(len_in);
   assign w_prod     = $signed(rdata_a) * $signed(rdata_b);
   assign w_prod_ext = ACC_WIDTH'(w_prod);

   assign rd_len   = (state == S_LEN) && !len_empty;
   assign rd_a     = w_pop;
   assign rd_b     = w_pop;
   assign wr_out   = (state == S_WRITE) && !out_full;
   assign done_out = (state == S_END);

   // Local vector store; contents deliberately survive reset and firings.
   always_ff @(posedge clk) begin
      if (w_pop) begin
         ram_a[w_addr] <= data_a_in;
         ram_b[w_addr] <= data_b_in;
      end
      if (state == S_COMP) begin
         rdata_a <= ram_a[w_addr];
         rdata_b <= ram_b[w_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         acc           <= '0;
         len_q         <= '0;
         idx           <= '0;
         mac_valid     <= 1'b0;
         len_err       <= 1'b0;
         next_mode_out <= M_LOAD;
      end else begin
         // Accumulate one cycle behind each RAM read issue.
         if (mac_valid) acc <= acc + w_prod_ext;
         mac_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_in) begin
                  idx <= '0;
                  case (next_mode_in)
                     M_LOAD: begin
                        state         <= S_LEN;
                        next_mode_out <= M_COMP;
                     end
                     M_COMP: begin
                        state         <= S_COMP;
                        acc           <= '0;
                        next_mode_out <= M_WRITE;
                     end
                     M_WRITE: begin
                        state         <= S_WRITE;
                        next_mode_out <= M_LOAD;
                     end
                     default: begin
                        state         <= S_END;
                        acc           <= '0;
                        len_q         <= '0;
                        len_err       <= 1'b0;
                        next_mode_out <= M_LOAD;
                     end
                  endcase
               end
            end
            S_LEN: begin
               if (!len_empty) begin
                  len_q   <= w_len;
                  len_err <= w_len_over;
                  idx     <= '0;
                  state   <= (w_len == '0) ? S_END : S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_pop) begin
                  if (idx == len_q - ONE_C) state <= S_END;
                  else                      idx   <= idx + ONE_C;
               end
            end
            S_COMP: begin
               if (len_q == '0) begin
                  state <= S_END;
               end else begin
                  mac_valid <= 1'b1;
                  if (idx == len_q - ONE_C) state <= S_DRAIN;
                  else                      idx   <= idx + ONE_C;
               end
            end
            S_DRAIN: state <= S_END;
            S_WRITE: begin
               if (!out_full) state <= S_END;
            end
            S_END:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      result_out = acc[WIDTH-1:0];
      sat_out    = 1'b0;
      if (acc > MAX_V) begin
         result_out = MAX_V[WIDTH-1:0];
         sat_out    = 1'b1;
      end else if (acc < MIN_V) begin
         result_out = MIN_V[WIDTH-1:0];
         sat_out    = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inner_product_firing_fsm_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_inner_product_firing_fsm_n
// Purpose  : Directed table-driven bench for inner_product_firing_fsm_n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inner_product_firing_fsm_n;

   localparam int WIDTH = 8;
   localparam int SIZE  = 4;
   localparam int NOWR  = -1000;
   localparam int NV    = 17;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_in;
   logic [1:0]       next_mode_in;
   logic [WIDTH-1:0] len_in;
   logic             len_empty;
   logic [WIDTH-1:0] data_a_in;
   logic             empty_a;
   logic [WIDTH-1:0] data_b_in;
   logic             empty_b;
   logic             out_full;
   logic             rd_len, rd_a, rd_b, wr_out;
   logic [WIDTH-1:0] result_out;
   logic             sat_out, len_err, done_out;
   logic [1:0]       next_mode_out;

   inner_product_firing_fsm_n #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .start_in(start_in), .next_mode_in(next_mode_in),
      .len_in(len_in), .len_empty(len_empty),
      .data_a_in(data_a_in), .empty_a(empty_a),
      .data_b_in(data_b_in), .empty_b(empty_b),
      .out_full(out_full),
      .rd_len(rd_len), .rd_a(rd_a), .rd_b(rd_b), .wr_out(wr_out),
      .result_out(result_out), .sat_out(sat_out), .len_err(len_err),
      .next_mode_out(next_mode_out), .done_out(done_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      int          len;
      int          np;
      logic [31:0] a;
      logic [31:0] b;
      int          done;
      logic [1:0]  nm;
      int          res;
      logic        sat;
      logic        lerr;
      int          pops;
      int          wr;
   } vec_t;

   vec_t vecs [NV];

   logic [7:0] qa [$];
   logic [7:0] qb [$];
   logic [7:0] ql [$];
   logic       force_eb, force_full;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cyc, done_cnt, pop_cnt, mask_pops, strobe_mm, wr_cnt, wr_cyc, dn;
   logic signed [7:0] wr_val;
   logic [1:0]        nm_at_done;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic present();
      empty_a   = (qa.size() == 0);
      data_a_in = (qa.size() == 0) ? 8'h00 : qa[0];
      empty_b   = (qb.size() == 0) || force_eb;
      data_b_in = (qb.size() == 0) ? 8'h00 : qb[0];
      len_empty = (ql.size() == 0);
      len_in    = (ql.size() == 0) ? 8'h00 : ql[0];
      out_full  = force_full;
   endtask

   task automatic load_tokens(input int len, input int np,
                              input logic [31:0] a, input logic [31:0] b);
      ql.push_back(8'(len));
      for (int j = 0; j < np; j++) begin
         qa.push_back(a[8*j +: 8]);
         qb.push_back(b[8*j +: 8]);
      end
   endtask

   // Start a firing at edge 0 and observe cycles 1..budget (sampled on negedge).
   task automatic run_firing(input logic [1:0] mode, input int budget,
                             input logic [31:0] eb_mask, input logic [31:0] full_mask);
      done_cyc = -1; done_cnt = 0; pop_cnt = 0; mask_pops = 0;
      strobe_mm = 0; wr_cnt = 0; wr_cyc = -1; wr_val = '0; nm_at_done = 2'b11;
      next_mode_in = mode;
      start_in     = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      for (int k = 1; k <= budget; k++) begin
         force_eb   = eb_mask[k];
         force_full = full_mask[k];
         present();
         @(negedge clk);
         if (rd_a !== rd_b) strobe_mm++;
         if (rd_a) begin
            pop_cnt++;
            if (eb_mask[k]) mask_pops++;
         end
         if (wr_out) begin
            wr_cnt++;
            wr_cyc = k;
            wr_val = result_out;
         end
         if (done_out) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc   = k;
               nm_at_done = next_mode_out;
            end
         end
         if (rd_len) void'(ql.pop_front());
         if (rd_a)   void'(qa.pop_front());
         if (rd_b)   void'(qb.pop_front());
         @(posedge clk); #1;
      end
      force_eb = 1'b0; force_full = 1'b0;
      present();
   endtask

   initial begin
      vecs[0]  = '{2'd0, 3, 3, 32'h00030201, 32'h00060504, 5, 2'd1,   0, 1'b0, 1'b0, 3, NOWR};
      vecs[1]  = '{2'd1, 0, 0, 32'h0,        32'h0,        5, 2'd2,  32, 1'b0, 1'b0, 0, NOWR};
      vecs[2]  = '{2'd2, 0, 0, 32'h0,        32'h0,        2, 2'd0,  32, 1'b0, 1'b0, 0, 32};
      vecs[3]  = '{2'd0, 4, 4, 32'h64646464, 32'h64646464, 6, 2'd1,  32, 1'b0, 1'b0, 4, NOWR};
      vecs[4]  = '{2'd1, 0, 0, 32'h0,        32'h0,        6, 2'd2, 127, 1'b1, 1'b0, 0, NOWR};
      vecs[5]  = '{2'd2, 0, 0, 32'h0,        32'h0,        2, 2'd0, 127, 1'b1, 1'b0, 0, 127};
      vecs[6]  = '{2'd0, 2, 2, 32'h00008080, 32'h00007f7f, 4, 2'd1, 127, 1'b1, 1'b0, 2, NOWR};
      vecs[7]  = '{2'd1, 0, 0, 32'h0,        32'h0,        4, 2'd2, -128, 1'b1, 1'b0, 0, NOWR};
      vecs[8]  = '{2'd0, 0, 0, 32'h0,        32'h0,        2, 2'd1, -128, 1'b1, 1'b0, 0, NOWR};
      vecs[9]  = '{2'd1, 0, 0, 32'h0,        32'h0,        2, 2'd2,   0, 1'b0, 1'b0, 0, NOWR};
      vecs[10] = '{2'd0, 7, 4, 32'h01010101, 32'h02020202, 6, 2'd1,   0, 1'b0, 1'b1, 4, NOWR};
      vecs[11] = '{2'd1, 0, 0, 32'h0,        32'h0,        6, 2'd2,   8, 1'b0, 1'b1, 0, NOWR};
      vecs[12] = '{2'd0, 2, 2, 32'h00000403, 32'h00000605, 4, 2'd1,   8, 1'b0, 1'b0, 2, NOWR};
      vecs[13] = '{2'd1, 0, 0, 32'h0,        32'h0,        4, 2'd2,  39, 1'b0, 1'b0, 0, NOWR};
      vecs[14] = '{2'd3, 0, 0, 32'h0,        32'h0,        1, 2'd0,   0, 1'b0, 1'b0, 0, NOWR};
      vecs[15] = '{2'd1, 0, 0, 32'h0,        32'h0,        2, 2'd2,   0, 1'b0, 1'b0, 0, NOWR};
      vecs[16] = '{2'd2, 0, 0, 32'h0,        32'h0,        2, 2'd0,   0, 1'b0, 1'b0, 0, 0};

      rst = 1'b1; start_in = 1'b0; next_mode_in = 2'b00;
      force_eb = 1'b0; force_full = 1'b0;
      present();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_outputs",
            {rd_len, rd_a, rd_b, wr_out, done_out, sat_out, len_err, next_mode_out, result_out}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].mode == 2'b00) load_tokens(vecs[i].len, vecs[i].np, vecs[i].a, vecs[i].b);
         run_firing(vecs[i].mode, 12, 32'h0, 32'h0);
         check($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].done);
         check($sformatf("v%0d_done_pulses", i), done_cnt, 1);
         check($sformatf("v%0d_next_mode", i), nm_at_done, vecs[i].nm);
         check($sformatf("v%0d_result", i), $signed(result_out), vecs[i].res);
         check($sformatf("v%0d_sat", i), sat_out, vecs[i].sat);
         check($sformatf("v%0d_len_err", i), len_err, vecs[i].lerr);
         check($sformatf("v%0d_pops", i), pop_cnt, vecs[i].pops);
         check($sformatf("v%0d_strobe_pair", i), strobe_mm, 0);
         check($sformatf("v%0d_writes", i), wr_cnt, (vecs[i].wr == NOWR) ? 0 : 1);
         if (vecs[i].wr != NOWR) check($sformatf("v%0d_write_value", i), wr_val, vecs[i].wr);
      end

      // B FIFO empty in cycles 3..5 stretches the LOAD by three cycles.
      load_tokens(3, 3, 32'h00030201, 32'h00010101);
      run_firing(2'b00, 12, 32'h0000_0038, 32'h0);
      check("stall_load_done_cycle", done_cyc, 8);
      check("stall_load_pops", pop_cnt, 3);
      check("stall_load_pops_while_empty", mask_pops, 0);
      check("stall_load_strobe_pair", strobe_mm, 0);
      run_firing(2'b01, 12, 32'h0, 32'h0);
      check("stall_comp_done_cycle", done_cyc, 5);
      check("stall_comp_result", $signed(result_out), 6);

      // Output FIFO full in cycles 1..4: single push at cycle 5.
      run_firing(2'b10, 12, 32'h0, 32'h0000_001e);
      check("full_write_done_cycle", done_cyc, 6);
      check("full_write_count", wr_cnt, 1);
      check("full_write_cycle", wr_cyc, 5);
      check("full_write_value", wr_val, 6);

      // Over-length LOAD, then reset sampled at edge 2 of a COMPUTE.
      load_tokens(5, 4, 32'h01010302, 32'h01010302);
      run_firing(2'b00, 12, 32'h0, 32'h0);
      check("overlen_done_cycle", done_cyc, 6);
      check("overlen_len_err", len_err, 1);
      next_mode_in = 2'b01;
      start_in     = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      present();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_no_done_before_edge", done_out, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_outputs_cleared",
            {rd_len, rd_a, rd_b, wr_out, done_out, sat_out, len_err, next_mode_out, result_out}, 0);
      dn = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done_out) dn++;
         @(posedge clk); #1;
      end
      check("rst_no_done_after", dn, 0);
      run_firing(2'b10, 12, 32'h0, 32'h0);
      check("post_rst_write_done_cycle", done_cyc, 2);
      check("post_rst_write_value", wr_val, 0);
      check("post_rst_write_count", wr_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/inner_product_firing_fsm_n.md
# inner_product_firing_fsm_n

Parametrised firing-state controller for the inner-product CFDF actor, driven by the actor's invoke FSM through a start/done handshake. Each firing runs one mode: LOAD (pop a runtime length token, then that many A/B token pairs into local RAM), COMPUTE (signed multiply-accumulate over local RAM), WRITE (emit the saturated result) or CLEAR (reset actor state). Compared with the fixed-size two-vector block, this one adds runtime vector length, FIFO empty/full back-pressure, a full-precision accumulator with output saturation, and a CLEAR mode.

## Interface
- SIZE, 8, maximum vector length and RAM depth (≥1)
- WIDTH, 16, signed token width of A, B and result
- ACC_WIDTH, 2*WIDTH+clog2(SIZE), accumulator width; no internal overflow is possible
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start_in  in  1  one-cycle start pulse from the parent FSM; sampled only in IDLE
- next_mode_in  in  2  mode for this firing: 00 LOAD, 01 COMPUTE, 10 WRITE, 11 CLEAR
- len_in, len_empty  in  WIDTH, 1  length FIFO head (unsigned, first-word-fall-through) and its empty flag
- data_a_in, empty_a  in  WIDTH, 1  A FIFO head (FWFT) and its empty flag
- data_b_in, empty_b  in  WIDTH, 1  B FIFO head (FWFT) and its empty flag
- out_full  in  1  output FIFO full flag
- rd_len, rd_a, rd_b  out  1 each  pop strobes
- wr_out  out  1  output FIFO push strobe
- result_out  out  WIDTH  saturated accumulator value
- sat_out  out  1  result_out is clipped
- len_err  out  1  last length token exceeded SIZE
- next_mode_out  out  2  CFDF next mode; valid when done_out=1
- done_out  out  1  one-cycle completion pulse to the parent

## Operation
- States: IDLE, LEN, LOAD, COMP, DRAIN, WRITE, END.
- IDLE: on start_in=1, go to LEN (00), COMP (01), WRITE (10) or END (11; CLEAR). CLEAR sets acc=0, L=0 and len_err=0.
- LEN: rd_len = !len_empty. On a pop, latch L = min(len_in, SIZE), set len_err = (len_in > SIZE), and clear idx. Next state is END if L=0, otherwise LOAD. With len_empty=1, stay in LEN.
- LOAD: rd_a = rd_b = !empty_a && !empty_b. Both strobes always assert together. On each pop, write A and B to RAM_A[idx] and RAM_B[idx], then idx++. After the pop at idx=L-1, go to END.
- COMP: on entry, acc=0. Issue RAM read address idx = 0..L-1, one per cycle; RAM read latency is 1. Each cycle after an issue, acc += signed(a)*signed(b), sign-extended to ACC_WIDTH. After the last issue, go to DRAIN (final accumulate), then END. With L=0, go straight to END and acc stays 0.
- WRITE: wr_out = !out_full. After one push, go to END. Exactly one push occurs per firing.
- END: done_out=1 for one cycle, then IDLE. next_mode_out is COMPUTE after LOAD, WRITE after COMPUTE, LOAD after WRITE, LOAD after CLEAR.
- result_out is combinational from acc: clipped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. sat_out=1 when clipped.
- RAM contents and L persist across firings. COMPUTE without a prior LOAD uses L=0.
- start_in outside IDLE is ignored. An invalid state recovers to IDLE.

## Timing
- Reset values (next edge with rst=1):
  - state=IDLE, acc=0, L=0, idx=0
  - rd_*, wr_out, done_out, sat_out, len_err = 0
  - result_out=0, next_mode_out=00
  - RAM is not cleared.
- Cycle 0 is the start_in edge.
- LOAD, no stalls: LEN at cycle 1, pops in cycles 2..L+1, done_out at cycle L+2. Each empty cycle adds one cycle.
- COMPUTE: issues in cycles 1..L, DRAIN at L+1, done_out at L+2. With L=0, done_out at cycle 2.
- WRITE: wr_out at cycle 1 if !out_full, done_out at cycle 2. Each full cycle adds one cycle.
- CLEAR: done_out at cycle 1.
- rst mid-firing: abort with no done_out. Any pending pop or push strobe is deasserted at that edge.

## Test plan
- WIDTH=8, SIZE=4, len 3, A=[1,2,3], B=[4,5,6]. Run LOAD, COMPUTE, WRITE. Expect done_out at cycles 5, 5 and 2; result_out=32 and sat_out=0; next_mode_out sequence 01, 10, 00.
- Len 4, A=B=[100]×4 (acc=40000). Expect result_out=127, sat_out=1. Repeat with A=[-128,-128], B=[127,127]. Expect result_out=-128, sat_out=1.
- LOAD with empty_b=1 in cycles 3–5. Expect rd_a=rd_b=0 in those cycles and done_out delayed by 3 cycles. WRITE with out_full=1 for 4 cycles. Expect a single wr_out pulse at cycle 5.
- Len 0. Expect no rd_a/rd_b and done_out at cycle 2. A following COMPUTE gives result 0. Len 7. Expect L=4 and len_err=1. A following len-2 LOAD clears len_err.
- rst in cycle 2 of COMPUTE. Expect no done_out, all outputs 0 after the edge, and a following WRITE outputs 0. After CLEAR, expect next_mode_out=00 and acc=0.
